// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive engine.
// Contents:
//   rx_state_t     receiver FSM state encoding
//   MIN_DATA_BITS  smallest accepted frame length
//   FLAG_*         bit positions of the error flags above the data field
//   majority3      2-of-3 vote used for bit sampling
//   parity_of      XOR reduction used for parity checking
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int MIN_DATA_BITS = 5;

    // Flag field sits directly above the data field in each FIFO entry.
    localparam int FLAG_W       = 3;
    localparam int FLAG_PARITY  = 0;
    localparam int FLAG_FRAMING = 1;
    localparam int FLAG_BREAK   = 2;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic parity_of(input logic [15:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous receive FIFO with a registered head entry.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   wr_en, wr_data  write request and entry
//   rd_en           pop request (ignored when empty)
//   rd_data         head entry (zero when empty)
//   valid           FIFO non-empty
//   count           occupancy 0..DEPTH
//   overrun         sticky: a write was dropped because the FIFO was full
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] head_r;
    logic             valid_r;
    logic             overrun_r;

    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [AW-1:0]    rd_ptr_inc_s;
    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] head_next_s;

    // Push/pop qualification, next occupancy and next head entry.
    always_comb begin
        full_s       = (count_r == FULL_COUNT);
        pop_s        = rd_en && valid_r;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        push_s       = wr_en && (!full_s || pop_s);
        drop_s       = wr_en && full_s && !pop_s;
        rd_ptr_inc_s = rd_ptr_r + PTR_ONE;
        count_next_s = count_r;
        head_next_s  = head_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = {WIDTH{1'b0}};
        end else if (count_r == {CW{1'b0}}) begin
            head_next_s = wr_data;
        end else if (pop_s) begin
            // The new head may be the entry being written this very cycle.
            if (push_s && (wr_ptr_r == rd_ptr_inc_s)) begin
                head_next_s = wr_data;
            end else begin
                head_next_s = mem_r[rd_ptr_inc_s];
            end
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage, pointers, occupancy, registered head and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            head_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            count_r <= count_next_s;
            head_r  <= head_next_s;
            valid_r <= (count_next_s != {CW{1'b0}});
            if (pop_s) begin
                overrun_r <= 1'b0;
            end else if (drop_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign rd_data = head_r;
    assign valid   = valid_r;
    assign count   = count_r;
    assign overrun = overrun_r;

endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampling UART receiver with majority-vote sampling,
// parity/framing/break detection and a receive FIFO.
// Ports:
//   clk_16bd      oversample clock (OVERSAMPLE ticks per bit)
//   rst           synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   parity_en     parity bit present
//   parity_type   0 even, 1 odd
//   stop_bits     0 one stop bit, 1 two stop bits
//   frame_length  data bits per frame (clamped to 5..MAX_DATA_BITS)
//   data_ready    consumer accepts head entry
//   data_out      head-entry data, LSB first received
//   data_valid    FIFO non-empty
//   parity_err, framing_err, break_det  head-entry flags
//   overrun       sticky frame-lost flag, cleared by the next pop
//   fifo_count    FIFO occupancy
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk_16bd,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          parity_en,
    input  logic                          parity_type,
    input  logic                          stop_bits,
    input  logic [3:0]                    frame_length,
    input  logic                          data_ready,
    output logic [MAX_DATA_BITS-1:0]      data_out,
    output logic                          data_valid,
    output logic                          parity_err,
    output logic                          framing_err,
    output logic                          break_det,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int ENTRY_W = MAX_DATA_BITS + FLAG_W;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_S2   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [3:0]    LEN_MIN   = 4'(MIN_DATA_BITS);
    localparam logic [3:0]    LEN_MAX   = 4'(MAX_DATA_BITS);

    rx_state_t state_r;
    rx_state_t state_next_s;

    logic                     sync1_r;
    logic                     rx_s;
    logic [TW-1:0]            tick_r;
    logic [2:0]               samp_r;
    logic [3:0]               bit_idx_r;
    logic                     stop_idx_r;
    logic [MAX_DATA_BITS-1:0] data_r;
    logic                     par_bit_r;
    logic                     par_en_r;
    logic                     par_type_r;
    logic                     stop2_r;
    logic [3:0]               len_r;

    logic                     bit_end_s;
    logic                     maj_s;
    logic                     wr_en_s;
    logic                     fe_s;
    logic                     brk_s;
    logic                     pe_s;
    logic [FLAG_W-1:0]        flags_s;
    logic [ENTRY_W-1:0]       entry_s;
    logic [ENTRY_W-1:0]       head_s;
    logic [3:0]               len_clamped_s;

    // Out-of-range frame lengths fall back to the widest supported frame.
    always_comb begin
        if ((frame_length < LEN_MIN) || (frame_length > LEN_MAX)) begin
            len_clamped_s = LEN_MAX;
        end else begin
            len_clamped_s = frame_length;
        end
    end

    // Next-state logic, FIFO write strobe and error flags of the frame.
    always_comb begin
        state_next_s = state_r;
        wr_en_s      = 1'b0;
        fe_s         = 1'b0;
        brk_s        = 1'b0;
        bit_end_s    = (tick_r == TICK_LAST);
        maj_s        = majority3(samp_r);
        pe_s         = par_en_r &&
                       ((parity_of(16'(data_r)) ^ par_bit_r) != par_type_r);
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    // A high start-bit vote is a glitch, not a frame.
                    if (maj_s) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_idx_r == (len_r - 4'd1))) begin
                    if (par_en_r) begin
                        state_next_s = PARITY;
                    end else begin
                        state_next_s = STOP;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    if (!maj_s) begin
                        // Bad stop bit: record the frame now and skip any
                        // remaining stop bit; wait for the line to recover.
                        fe_s         = 1'b1;
                        brk_s        = !stop_idx_r && (data_r == '0) &&
                                       (!par_en_r || !par_bit_r);
                        wr_en_s      = 1'b1;
                        state_next_s = WAIT_IDLE;
                    end else if (stop2_r && !stop_idx_r) begin
                        state_next_s = STOP;
                    end else begin
                        wr_en_s      = 1'b1;
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        flags_s               = {FLAG_W{1'b0}};
        flags_s[FLAG_PARITY]  = pe_s;
        flags_s[FLAG_FRAMING] = fe_s;
        flags_s[FLAG_BREAK]   = brk_s;
        entry_s               = {flags_s, data_r};
    end

    // State register.
    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Input synchroniser, bit timing, sampling and frame datapath.
    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            sync1_r    <= 1'b1;
            rx_s       <= 1'b1;
            tick_r     <= {TW{1'b0}};
            samp_r     <= 3'b000;
            bit_idx_r  <= 4'd0;
            stop_idx_r <= 1'b0;
            data_r     <= {MAX_DATA_BITS{1'b0}};
            par_bit_r  <= 1'b0;
            par_en_r   <= 1'b0;
            par_type_r <= 1'b0;
            stop2_r    <= 1'b0;
            len_r      <= LEN_MAX;
        end else begin
            sync1_r <= rx;
            rx_s    <= sync1_r;
            case (state_r)
                IDLE: begin
                    tick_r <= {TW{1'b0}};
                    samp_r <= 3'b000;
                    if (!rx_s) begin
                        // Configuration is frozen for the whole frame.
                        par_en_r   <= parity_en;
                        par_type_r <= parity_type;
                        stop2_r    <= stop_bits;
                        len_r      <= len_clamped_s;
                        data_r     <= {MAX_DATA_BITS{1'b0}};
                        bit_idx_r  <= 4'd0;
                        stop_idx_r <= 1'b0;
                        par_bit_r  <= 1'b0;
                    end else begin
                        len_r <= len_r;
                    end
                end
                WAIT_IDLE: begin
                    tick_r <= {TW{1'b0}};
                end
                default: begin
                    if (bit_end_s) begin
                        tick_r <= {TW{1'b0}};
                    end else begin
                        tick_r <= tick_r + TICK_ONE;
                    end
                    if (tick_r == TICK_S0) begin
                        samp_r[0] <= rx_s;
                    end else if (tick_r == TICK_S1) begin
                        samp_r[1] <= rx_s;
                    end else if (tick_r == TICK_S2) begin
                        samp_r[2] <= rx_s;
                    end else begin
                        samp_r <= samp_r;
                    end
                    if (bit_end_s) begin
                        if (state_r == DATA) begin
                            data_r[bit_idx_r] <= maj_s;
                            bit_idx_r         <= bit_idx_r + 4'd1;
                        end else if (state_r == PARITY) begin
                            par_bit_r <= maj_s;
                        end else if (state_r == STOP) begin
                            stop_idx_r <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r;
                        end
                    end else begin
                        bit_idx_r <= bit_idx_r;
                    end
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_16bd),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_data (entry_s),
        .rd_en   (data_ready),
        .rd_data (head_s),
        .valid   (data_valid),
        .count   (fifo_count),
        .overrun (overrun)
    );

    assign data_out    = head_s[MAX_DATA_BITS-1:0];
    assign parity_err  = head_s[MAX_DATA_BITS + FLAG_PARITY];
    assign framing_err = head_s[MAX_DATA_BITS + FLAG_FRAMING];
    assign break_det   = head_s[MAX_DATA_BITS + FLAG_BREAK];

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: directed self-checking bench for uart_rx_engine.
module tb_uart_rx_engine;
    import uart_pkg::*;

    localparam int OS  = 16;
    localparam int MDB = 9;
    localparam int FD  = 4;

    logic            clk_16bd = 1'b0;
    logic            rst;
    logic            rx;
    logic            parity_en;
    logic            parity_type;
    logic            stop_bits;
    logic [3:0]      frame_length;
    logic            data_ready;
    logic [MDB-1:0]  data_out;
    logic            data_valid;
    logic            parity_err;
    logic            framing_err;
    logic            break_det;
    logic            overrun;
    logic [2:0]      fifo_count;

    int checks = 0;
    int errors = 0;
    logic [11:0] popped [$];

    always #5 clk_16bd = ~clk_16bd;

    uart_rx_engine #(
        .OVERSAMPLE    (OS),
        .MAX_DATA_BITS (MDB),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk_16bd     (clk_16bd),
        .rst          (rst),
        .rx           (rx),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .frame_length (frame_length),
        .data_ready   (data_ready),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .break_det    (break_det),
        .overrun      (overrun),
        .fifo_count   (fifo_count)
    );

    // Record every entry the consumer accepts as {break, framing, parity, data}.
    always @(negedge clk_16bd) begin
        if (!rst && data_valid && data_ready) begin
            popped.push_back({break_det, framing_err, parity_err, data_out});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk_16bd);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        ticks(OS);
    endtask

    task automatic send_frame(input logic [8:0] d, input int n, input logic pen,
                              input logic pbit, input logic s0, input logic s1,
                              input logic two);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) begin
            send_bit(d[i]);
        end
        if (pen) send_bit(pbit);
        send_bit(s0);
        if (two) send_bit(s1);
        rx = 1'b1;
        ticks(2 * OS);
    endtask

    task automatic pop();
        data_ready = 1'b1;
        ticks(1);
        data_ready = 1'b0;
    endtask

    task automatic cfg(input logic pen, input logic ptype, input logic sb, input logic [3:0] len);
        parity_en    = pen;
        parity_type  = ptype;
        stop_bits    = sb;
        frame_length = len;
    endtask

    initial begin
        rx         = 1'b1;
        rst        = 1'b1;
        data_ready = 1'b0;
        cfg(1'b0, 1'b0, 1'b0, 4'd8);
        ticks(4);
        rst = 1'b0;
        ticks(2);

        // Reset state
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_flags", {29'd0, break_det, framing_err, parity_err}, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_state", 32'(dut.state_r), 32'(IDLE));

        // 8N1 0x55 with consumer always ready
        popped.delete();
        data_ready = 1'b1;
        send_frame(9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        data_ready = 1'b0;
        check("8n1_pops", 32'(popped.size()), 32'd1);
        if (popped.size() > 0) check("8n1_entry", 32'(popped[0]), 32'h055);
        check("8n1_count", 32'(fifo_count), 32'd0);

        // 7E1 0x41 with wrong parity bit
        cfg(1'b1, 1'b0, 1'b0, 4'd7);
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("7e1_count", 32'(fifo_count), 32'd1);
        check("7e1_data", 32'(data_out), 32'h041);
        check("7e1_perr", 32'(parity_err), 32'd1);
        check("7e1_ferr", 32'(framing_err), 32'd0);
        pop();

        // Odd parity with a correct parity bit: 0x41 has two ones -> bit 1
        cfg(1'b1, 1'b1, 1'b0, 4'd7);
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("7o1_data", 32'(data_out), 32'h041);
        check("7o1_perr", 32'(parity_err), 32'd0);
        pop();

        // Out-of-range length clamps to 9 bits
        cfg(1'b0, 1'b0, 1'b0, 4'd15);
        send_frame(9'h1A5, 9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clamp_data", 32'(data_out), 32'h1A5);
        pop();

        // Start glitch shorter than half a bit is rejected
        cfg(1'b0, 1'b0, 1'b0, 4'd8);
        rx = 1'b0;
        ticks(3);
        rx = 1'b1;
        ticks(2 * OS);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_state", 32'(dut.state_r), 32'(IDLE));

        // Break: line low for 12 bit times at 8N1
        rx = 1'b0;
        ticks(12 * OS);
        check("brk_count", 32'(fifo_count), 32'd1);
        check("brk_data", 32'(data_out), 32'd0);
        check("brk_break", 32'(break_det), 32'd1);
        check("brk_ferr", 32'(framing_err), 32'd1);
        check("brk_state", 32'(dut.state_r), 32'(WAIT_IDLE));
        pop();
        ticks(2 * OS);
        check("brk_hold_count", 32'(fifo_count), 32'd0);
        rx = 1'b1;
        ticks(OS);
        check("brk_recover_state", 32'(dut.state_r), 32'(IDLE));
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("post_brk_data", 32'(data_out), 32'h03C);
        check("post_brk_flags", {29'd0, break_det, framing_err, parity_err}, 32'd0);
        pop();

        // 8N2 0xA3 with second stop bit low
        cfg(1'b0, 1'b0, 1'b1, 4'd8);
        send_frame(9'h0A3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("8n2_data", 32'(data_out), 32'h0A3);
        check("8n2_ferr", 32'(framing_err), 32'd1);
        check("8n2_break", 32'(break_det), 32'd0);
        pop();

        // Configuration change mid-frame is ignored (frame latched as 8N1)
        cfg(1'b0, 1'b0, 1'b0, 4'd8);
        fork
            send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            begin
                ticks(3 * OS);
                cfg(1'b1, 1'b1, 1'b1, 4'd5);
            end
        join
        check("cfg_hold_data", 32'(data_out), 32'h0C3);
        check("cfg_hold_flags", {29'd0, break_det, framing_err, parity_err}, 32'd0);
        pop();
        cfg(1'b0, 1'b0, 1'b0, 4'd8);

        // Overrun: five frames into a four-entry FIFO
        for (int k = 1; k <= 5; k++) begin
            send_frame(9'(k), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        check("ovr_count", 32'(fifo_count), 32'd4);
        check("ovr_flag", 32'(overrun), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check("ovr_pop_data", 32'(data_out), 32'(k));
            pop();
            if (k == 1) check("ovr_cleared", 32'(overrun), 32'd0);
        end
        check("ovr_empty_count", 32'(fifo_count), 32'd0);
        check("ovr_empty_valid", 32'(data_valid), 32'd0);
        pop();
        check("empty_pop_count", 32'(fifo_count), 32'd0);

        // Reset in mid-frame abandons the frame
        rx = 1'b0;
        ticks(5 * OS);
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        rx  = 1'b1;
        ticks(2 * OS);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_state", 32'(dut.state_r), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
